// File: rtl/nucore_pkg.sv
// Shared types and default sizing for the nucore instruction sequencer.
package nucore_pkg;

    localparam int unsigned NUCORE_ADDR_W     = 6;
    localparam int unsigned NUCORE_PIPE_DEPTH = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StDrain,
        StDone
    } nucore_state_e;

endpackage

// File: rtl/nucore_drain_timer.sv
// Loadable down-counter; expired_o is high once the loaded count has run out.
module nucore_drain_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/nucore_sequencer.sv
// Run/step/halt instruction sequencer with pipeline drain.
// Define NUCORE_ZHALT_EN to let z_flag halt free-running execution like halt_req.
module nucore_sequencer
    import nucore_pkg::*;
#(
    parameter int unsigned ADDR_W     = NUCORE_ADDR_W,
    parameter int unsigned PIPE_DEPTH = NUCORE_PIPE_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              z_flag,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] count,
    output logic              flush,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DrainW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    nucore_state_e     state_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] last_q;
    logic              pc_enable_q;
    logic              flush_q;
    logic              busy_q;
    logic              done_q;
    logic              halted_q;
    logic              last_hit_q;

    logic              run_halt;
    logic              fetch_last;
    logic              run_exit;
    logic [ADDR_W-1:0] count_inc;
    logic              drain_load;
    logic              drain_dec;
    logic              drain_expired;

`ifdef NUCORE_ZHALT_EN
    assign run_halt = halt_req | z_flag;
`else
    logic unused_z_flag;
    assign unused_z_flag = z_flag;
    assign run_halt      = halt_req;
`endif

    // The address after last_q wraps to 0, so count never exceeds last_q.
    assign fetch_last = (count_q == last_q);
    assign count_inc  = fetch_last ? '0 : count_q + ADDR_W'(1);
    assign run_exit   = run_halt || fetch_last;

    always_comb begin
        drain_load = 1'b0;
        case (state_q)
            StRun:   drain_load = run_exit;
            StStep:  drain_load = 1'b1;
            default: drain_load = 1'b0;
        endcase
    end

    assign drain_dec = (state_q == StDrain);

    nucore_drain_timer #(
        .Width (DrainW)
    ) u_drain_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (drain_load),
        .load_val_i (DrainW'(PIPE_DEPTH - 1)),
        .dec_i      (drain_dec),
        .expired_o  (drain_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            last_q      <= '0;
            pc_enable_q <= 1'b0;
            flush_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            last_hit_q  <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (step || run) begin
                        state_q     <= step ? StStep : StRun;
                        last_q      <= prog_len;
                        pc_enable_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StRun: begin
                    count_q <= count_inc;
                    if (run_exit) begin
                        state_q     <= StDrain;
                        pc_enable_q <= 1'b0;
                        halted_q    <= run_halt;
                        last_hit_q  <= fetch_last;
                    end
                end
                StStep: begin
                    count_q     <= count_inc;
                    state_q     <= StDrain;
                    pc_enable_q <= 1'b0;
                    halted_q    <= 1'b0;
                    last_hit_q  <= fetch_last;
                end
                StDrain: begin
                    if (halt_req) begin
                        halted_q <= 1'b1;
                    end
                    if (drain_expired) begin
                        busy_q <= 1'b0;
                        if (last_hit_q || halted_q || halt_req) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StIdle;
                            halted_q   <= 1'b0;
                            last_hit_q <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (!run && !step) begin
                        state_q    <= StIdle;
                        done_q     <= 1'b0;
                        flush_q    <= 1'b1;
                        count_q    <= '0;
                        halted_q   <= 1'b0;
                        last_hit_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pc_enable = pc_enable_q;
    assign count     = count_q;
    assign flush     = flush_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_nucore_sequencer.sv
// Directed bench for nucore_sequencer: a vector table plus multi-cycle corner sequences.
module tb_nucore_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       step;
    logic       halt_req;
    logic [5:0] prog_len;
    logic       z_flag;
    logic       pc_enable;
    logic [5:0] count;
    logic       flush;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;
    int pc_cnt;
    logic done_seen;

    nucore_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .halt_req  (halt_req),
        .prog_len  (prog_len),
        .z_flag    (z_flag),
        .pc_enable (pc_enable),
        .count     (count),
        .flush     (flush),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       run;
        logic       step;
        logic       halt;
        logic [5:0] plen;
        logic       pc;
        logic [5:0] cnt;
        logic       fl;
        logic       bsy;
        logic       dn;
    } vec_t;

    localparam int NVec = 19;
    vec_t vecs [NVec];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_enable) pc_cnt++;
        if (done) done_seen = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        halt_req = 1'b0;
        z_flag   = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_count(input logic [5:0] tgt, input string nm);
        int k;
        k = 0;
        while (count != tgt && k < 200) begin
            tick();
            k++;
        end
        check({nm, "_reach"}, 32'(count), 32'(tgt));
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 200) begin
            tick();
            k++;
        end
        check({nm, "_done"}, 32'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        pc_cnt    = 0;
        done_seen = 1'b0;
        reset     = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        halt_req  = 1'b0;
        z_flag    = 1'b0;
        prog_len  = '0;

        //          rst  run  step halt plen   pc   cnt  fl   bsy  dn
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd4,  1'b0, 6'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd4,  1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd4,  1'b1, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b1, 6'd1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b1, 6'd2, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b1, 6'd3, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b1, 6'd4, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd9,  1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd10, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 6'd1, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NVec; i++) begin
            reset    = vecs[i].rst;
            run      = vecs[i].run;
            step     = vecs[i].step;
            halt_req = vecs[i].halt;
            prog_len = vecs[i].plen;
            tick();
            check($sformatf("vec%0d.pc_enable", i), 32'(pc_enable), 32'(vecs[i].pc));
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.flush", i), 32'(flush), 32'(vecs[i].fl));
            check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].dn));
        end

        // Three spaced single steps.
        do_reset();
        prog_len  = 6'd10;
        pc_cnt    = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (6) tick();
            check($sformatf("step%0d_idle_busy", k), 32'(busy), 0);
        end
        check("step_pc_pulses", 32'(pc_cnt), 3);
        check("step_count", 32'(count), 3);
        check("step_done_seen", 32'(done_seen), 0);

        // Halt during RUN at count 6.
        do_reset();
        prog_len = 6'd20;
        run      = 1'b1;
        tick();
        wait_count(6'd6, "halt");
        halt_req = 1'b1;
        pc_cnt   = 0;
        tick();
        halt_req = 1'b0;
        check("halt_drain1_busy", 32'(busy), 1);
        tick();
        check("halt_drain2_busy", 32'(busy), 1);
        tick();
        check("halt_drain3_busy", 32'(busy), 1);
        check("halt_drain3_done", 32'(done), 0);
        tick();
        check("halt_done", 32'(done), 1);
        check("halt_no_fetch", 32'(pc_cnt), 0);
        run = 1'b0;
        tick();
        check("halt_exit_flush", 32'(flush), 1);
        check("halt_exit_count", 32'(count), 0);

        // Reset in the middle of RUN.
        do_reset();
        prog_len = 6'd20;
        run      = 1'b1;
        tick();
        wait_count(6'd5, "rstmid");
        reset = 1'b0;
        tick();
        check("rstmid_count", 32'(count), 0);
        check("rstmid_flush", 32'(flush), 1);
        check("rstmid_pc_enable", 32'(pc_enable), 0);
        check("rstmid_busy", 32'(busy), 0);
        reset = 1'b1;
        run   = 1'b0;
        tick();
        check("rstmid_flush_release", 32'(flush), 0);

        // Full-range program wraps count back to 0.
        do_reset();
        prog_len = 6'd63;
        run      = 1'b1;
        pc_cnt   = 0;
        wait_done("wrap");
        check("wrap_fetches", 32'(pc_cnt), 64);
        check("wrap_count", 32'(count), 0);
        run = 1'b0;
        tick();

        // Halt arriving mid-drain after a step keeps the drain length but ends in DONE.
        do_reset();
        prog_len = 6'd10;
        step     = 1'b1;
        tick();
        step = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check("dhalt_drain3_busy", 32'(busy), 1);
        check("dhalt_drain3_done", 32'(done), 0);
        tick();
        check("dhalt_done", 32'(done), 1);
        tick();

        // z_flag pulse at count 3.
        do_reset();
        prog_len = 6'd20;
        run      = 1'b1;
        pc_cnt   = 0;
        tick();
        wait_count(6'd3, "zflag");
        z_flag = 1'b1;
        tick();
        z_flag = 1'b0;
        wait_done("zflag");
`ifdef NUCORE_ZHALT_EN
        check("zflag_fetches", 32'(pc_cnt), 4);
`else
        check("zflag_fetches", 32'(pc_cnt), 21);
`endif
        run = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
